// File: rtl/compare_pkg.sv
// Shared types for the serial magnitude comparator: FSM states and the
// one-hot {greater, equal, smaller} result encoding.
package compare_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef logic [2:0] cmp_t;

  localparam cmp_t CMP_GT   = 3'b100;
  localparam cmp_t CMP_EQ   = 3'b010;
  localparam cmp_t CMP_LT   = 3'b001;
  localparam cmp_t CMP_NONE = 3'b000;

endpackage

// File: rtl/compare_digit.sv
// Combinational unsigned compare of one digit pair, returning the one-hot
// {greater, equal, smaller} code.
module compare_digit
  import compare_pkg::*;
#(
  parameter int DIGIT_WIDTH = 4
) (
  input  logic [DIGIT_WIDTH-1:0] a_digit,
  input  logic [DIGIT_WIDTH-1:0] b_digit,
  output logic [2:0]             result
);

  always_comb begin
    if (a_digit > b_digit) begin
      result = CMP_GT;
    end else if (a_digit < b_digit) begin
      result = CMP_LT;
    end else begin
      result = CMP_EQ;
    end
  end

endmodule

// File: rtl/compare_serial_nbit.sv
// Iterative MSB-first magnitude comparator, one DIGIT_WIDTH digit per clock.
// Define CMP_EARLY_EXIT_EN to stop at the first differing digit.
module compare_serial_nbit
  import compare_pkg::*;
#(
  parameter int CMP_WIDTH   = 16,
  parameter int DIGIT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [CMP_WIDTH-1:0] a,
  input  logic [CMP_WIDTH-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic                 greater,
  output logic                 equal,
  output logic                 smaller
);

  localparam int NUM_DIGITS = CMP_WIDTH / DIGIT_WIDTH;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  state_t               state;
  state_t               next_state;
  logic [CMP_WIDTH-1:0] a_sh;
  logic [CMP_WIDTH-1:0] b_sh;
  logic [IDX_W-1:0]     idx;
  cmp_t                 partial;
  cmp_t                 partial_next;
  cmp_t                 digit_res;
  logic                 load;
  logic                 last_digit;

  compare_digit #(
    .DIGIT_WIDTH(DIGIT_WIDTH)
  ) u_digit (
    .a_digit(a_sh[CMP_WIDTH-1 -: DIGIT_WIDTH]),
    .b_digit(b_sh[CMP_WIDTH-1 -: DIGIT_WIDTH]),
    .result (digit_res)
  );

  // NOTE: every always_comb output gets a default first so no path leaves
  // a value unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state   = state;
    load         = 1'b0;
    partial_next = partial;
    if ((partial == CMP_NONE) && (digit_res != CMP_EQ)) begin
      partial_next = digit_res;
    end
`ifdef CMP_EARLY_EXIT_EN
    last_digit = (idx == '0) || (digit_res != CMP_EQ);
`else
    last_digit = (idx == '0);
`endif
    case (state)
      IDLE: begin
        if (start) begin
          next_state = RUN;
          load       = 1'b1;
        end
      end
      RUN: begin
        if (last_digit) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      idx     <= '0;
      partial <= CMP_NONE;
      done    <= 1'b0;
      greater <= 1'b0;
      equal   <= 1'b0;
      smaller <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        // Flipping the sign bit maps two's complement onto offset binary,
        // so the unsigned digit compare orders signed values correctly.
        a_sh    <= {a[CMP_WIDTH-1] ^ is_signed, a[CMP_WIDTH-2:0]};
        b_sh    <= {b[CMP_WIDTH-1] ^ is_signed, b[CMP_WIDTH-2:0]};
        idx     <= IDX_W'(NUM_DIGITS - 1);
        partial <= CMP_NONE;
      end else if (state == RUN) begin
        a_sh    <= a_sh << DIGIT_WIDTH;
        b_sh    <= b_sh << DIGIT_WIDTH;
        idx     <= idx - IDX_W'(1);
        partial <= partial_next;
        if (last_digit) begin
          {greater, equal, smaller} <= (partial_next == CMP_NONE) ? CMP_EQ : partial_next;
          done <= 1'b1;
        end
      end
    end
  end

  assign busy = (state == RUN);

endmodule
